// File: rtl/mux_sel_scanner.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_scanner
// Brief    : Round-robin 4:1 mux select scanner. Dwells on each channel,
//            samples the mux output, and delivers 4-bit frames over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_scanner #(
    parameter int DWELL = 4,
    parameter int FCW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           mux_in,
    output logic [1:0]     sel,
    output logic [3:0]     frame_data,
    output logic           frame_valid,
    input  logic           frame_ready,
    output logic [FCW-1:0] frame_cnt,
    output logic           busy
);

    localparam logic [1:0]     c_idle = 2'd0;
    localparam logic [1:0]     c_scan = 2'd1;
    localparam logic [1:0]     c_wait = 2'd2;
    localparam logic [7:0]     c_last = 8'(DWELL - 1);
    localparam logic [FCW-1:0] c_one  = FCW'(1);

    logic [1:0]     r_state;
    logic [1:0]     w_next;
    logic [7:0]     r_cnt;
    logic [1:0]     r_sel;
    logic [3:0]     r_buf;
    logic [3:0]     r_data;
    logic           r_valid;
    logic [FCW-1:0] r_fcnt;

    logic           w_dwell_end;
    logic           w_complete;
    logic           w_slot_free;
    logic           w_load_scan;
    logic           w_load_wait;
    logic           w_busy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (en) w_next = c_scan;
            end
            c_scan: begin
                if (w_complete) begin
                    if (w_slot_free) w_next = en ? c_scan : c_idle;
                    else             w_next = c_wait;
                end
            end
            c_wait: begin
                if (frame_ready) w_next = en ? c_scan : c_idle;
            end
            default: w_next = c_idle;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        w_dwell_end = (r_state == c_scan) && (r_cnt == c_last);
        w_complete  = w_dwell_end && (r_sel == 2'd3);
        w_slot_free = !r_valid || frame_ready;
        w_load_scan = w_complete && w_slot_free;
        w_load_wait = (r_state == c_wait) && frame_ready;
        w_busy      = (r_state != c_idle);
    end

    // Scan datapath: dwell counter, select and sample buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
            r_sel <= 2'd0;
            r_buf <= 4'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_cnt <= 8'd0;
                    r_sel <= 2'd0;
                end
                c_scan: begin
                    if (w_dwell_end) begin
                        r_cnt        <= 8'd0;
                        r_buf[r_sel] <= mux_in;
                        // A blocked frame parks on channel 3 until the slot drains
                        if (r_sel != 2'd3)    r_sel <= r_sel + 2'd1;
                        else if (w_slot_free) r_sel <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_wait: begin
                    if (frame_ready) r_sel <= 2'd0;
                end
                default: begin
                    r_cnt <= 8'd0;
                    r_sel <= 2'd0;
                end
            endcase
        end
    end

    // Output slot: a load always wins over a plain acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= 4'd0;
            r_valid <= 1'b0;
            r_fcnt  <= '0;
        end else if (w_load_scan) begin
            r_data  <= {mux_in, r_buf[2:0]};
            r_valid <= 1'b1;
            r_fcnt  <= r_fcnt + c_one;
        end else if (w_load_wait) begin
            r_data  <= r_buf;
            r_valid <= 1'b1;
            r_fcnt  <= r_fcnt + c_one;
        end else if (frame_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign sel         = r_sel;
    assign frame_data  = r_data;
    assign frame_valid = r_valid;
    assign frame_cnt   = r_fcnt;
    assign busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_scanner
// Brief    : Directed self-checking bench for mux_sel_scanner (DWELL=4/FCW=8
//            and DWELL=1/FCW=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ready;
    logic [3:0] chan;
    logic       mux_in;
    logic [1:0] sel;
    logic [3:0] fdata;
    logic       fvalid;
    logic [7:0] fcnt;
    logic       busy;

    logic       en2;
    logic       ready2;
    logic       mux2_in;
    logic [1:0] sel2;
    logic [3:0] fdata2;
    logic       fvalid2;
    logic [1:0] fcnt2;
    logic       busy2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Bench-side 4:1 mux model driven by the scanner's select
    assign mux_in = chan[sel];

    mux_sel_scanner #(.DWELL(4), .FCW(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mux_in      (mux_in),
        .sel         (sel),
        .frame_data  (fdata),
        .frame_valid (fvalid),
        .frame_ready (ready),
        .frame_cnt   (fcnt),
        .busy        (busy)
    );

    mux_sel_scanner #(.DWELL(1), .FCW(2)) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .en          (en2),
        .mux_in      (mux2_in),
        .sel         (sel2),
        .frame_data  (fdata2),
        .frame_valid (fvalid2),
        .frame_ready (ready2),
        .frame_cnt   (fcnt2),
        .busy        (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [3:0] e2 [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        e2[0] = 4'b0101;
        e2[1] = 4'b1010;
        e2[2] = 4'b0011;
        e2[3] = 4'b1100;

        rst = 1'b1; en = 1'b0; ready = 1'b1; chan = 4'd0;
        en2 = 1'b0; ready2 = 1'b1; mux2_in = 1'b0;
        tick_n(2);
        check("rst_sel",   32'(sel),    32'd0);
        check("rst_valid", 32'(fvalid), 32'd0);
        check("rst_data",  32'(fdata),  32'd0);
        check("rst_cnt",   32'(fcnt),   32'd0);
        check("rst_busy",  32'(busy),   32'd0);

        // Single frame with a free slot; en seen at edge 0
        rst = 1'b0; en = 1'b1; chan = 4'b1101;
        tick();
        check("t1_busy_e0", 32'(busy), 32'd1);
        check("t1_sel_e0",  32'(sel),  32'd0);
        tick_n(4);  check("t1_sel_e4",  32'(sel), 32'd1);
        tick_n(4);  check("t1_sel_e8",  32'(sel), 32'd2);
        tick_n(4);  check("t1_sel_e12", 32'(sel), 32'd3);
        tick_n(3);  check("t1_valid_e15", 32'(fvalid), 32'd0);
        tick();
        check("t1_valid_e16", 32'(fvalid), 32'd1);
        check("t1_data_e16",  32'(fdata),  32'b1101);
        check("t1_cnt_e16",   32'(fcnt),   32'd1);
        check("t1_sel_e16",   32'(sel),    32'd0);
        tick();
        check("t1_valid_e17", 32'(fvalid), 32'd0);
        check("t1_busy_e17",  32'(busy),   32'd1);

        // Continuous throughput
        tick_n(15);
        check("t2_valid_e32", 32'(fvalid), 32'd1);
        check("t2_cnt_e32",   32'(fcnt),   32'd2);
        tick_n(48);
        check("t2_valid_e80", 32'(fvalid), 32'd1);
        check("t2_cnt_e80",   32'(fcnt),   32'd5);

        // Reset mid-scan with en held high
        tick_n(8);
        rst = 1'b1;
        tick();
        check("t5_sel",   32'(sel),    32'd0);
        check("t5_valid", 32'(fvalid), 32'd0);
        check("t5_data",  32'(fdata),  32'd0);
        check("t5_cnt",   32'(fcnt),   32'd0);
        check("t5_busy",  32'(busy),   32'd0);
        rst = 1'b0;
        tick();
        check("t5_restart_busy", 32'(busy), 32'd1);
        check("t5_restart_sel",  32'(sel),  32'd0);
        tick_n(16);
        check("t5_valid", 32'(fvalid), 32'd1);
        check("t5_cnt2",  32'(fcnt),   32'd1);
        check("t5_data2", 32'(fdata),  32'b1101);

        // Backpressure into WAIT
        rst = 1'b1; en = 1'b0; tick();
        rst = 1'b0; ready = 1'b0; en = 1'b1; chan = 4'b1001;
        tick();
        tick_n(16);
        check("t3_valid_e16", 32'(fvalid), 32'd1);
        check("t3_data_e16",  32'(fdata),  32'b1001);
        check("t3_cnt_e16",   32'(fcnt),   32'd1);
        chan = 4'b0110;
        tick_n(16);
        check("t3_sel_e32",   32'(sel),   32'd3);
        check("t3_busy_e32",  32'(busy),  32'd1);
        check("t3_data_e32",  32'(fdata), 32'b1001);
        check("t3_cnt_e32",   32'(fcnt),  32'd1);
        tick_n(8);
        check("t3_sel_e40",   32'(sel),    32'd3);
        check("t3_data_e40",  32'(fdata),  32'b1001);
        check("t3_valid_e40", 32'(fvalid), 32'd1);
        ready = 1'b1;
        tick();
        check("t3_data_e41",  32'(fdata),  32'b0110);
        check("t3_cnt_e41",   32'(fcnt),   32'd2);
        check("t3_valid_e41", 32'(fvalid), 32'd1);
        check("t3_sel_e41",   32'(sel),    32'd0);
        tick();
        check("t3_valid_e42", 32'(fvalid), 32'd0);
        tick_n(15);
        check("t3_cnt_e57",   32'(fcnt),  32'd3);
        check("t3_data_e57",  32'(fdata), 32'b0110);

        // en dropped mid-frame
        rst = 1'b1; en = 1'b0; tick();
        rst = 1'b0; ready = 1'b1; en = 1'b1; chan = 4'b1110;
        tick();
        tick_n(6);
        en = 1'b0;
        tick_n(10);
        check("t4_valid_e16", 32'(fvalid), 32'd1);
        check("t4_data_e16",  32'(fdata),  32'b1110);
        check("t4_cnt_e16",   32'(fcnt),   32'd1);
        check("t4_busy_e16",  32'(busy),   32'd0);
        check("t4_sel_e16",   32'(sel),    32'd0);
        tick_n(4);
        check("t4_busy_e20",  32'(busy),   32'd0);
        check("t4_valid_e20", 32'(fvalid), 32'd0);

        // DWELL=1, FCW=2: one frame per 4 clocks, counter wraps
        rst = 1'b1; tick();
        rst = 1'b0; en2 = 1'b1;
        tick();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) begin
                mux2_in = e2[f][k];
                tick();
                if (f == 1 && k == 0) check("t6_valid_gap", 32'(fvalid2), 32'd0);
            end
            check("t6_valid", 32'(fvalid2), 32'd1);
            check("t6_data",  32'(fdata2),  32'(e2[f]));
            check("t6_cnt",   32'(fcnt2),   32'((f + 1) % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
